frame_plotter: RTL

// Raster-scan pixel writer between the game datapath and the VGA adapter write port
// (x, y, colour, plot). On a one-cycle start pulse it walks every pixel of the
// 160x120 screen, asks the datapath which object occupies it, and emits one plot per

---
 rtl/game_pkg.sv | 22 ++
 rtl/frame_plotter_raster_counter.sv | 52 +++++
 rtl/frame_plotter.sv | 114 +++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game constants: screen geometry, colour palette and plotter FSM encoding.
package game_pkg;

  localparam int unsigned H_RES    = 160;
  localparam int unsigned V_RES    = 120;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;

  localparam logic [COLOUR_W-1:0] BG_COLOUR   = 3'b000;
  localparam logic [COLOUR_W-1:0] WALL_COLOUR = 3'b010;
  localparam logic [COLOUR_W-1:0] DUDE_COLOUR = 3'b110;
  localparam logic [COLOUR_W-1:0] MENU_COLOUR = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } plot_state_e;

endpackage

// File: rtl/frame_plotter_raster_counter.sv
// Raster x/y scan counter: x wraps at the line end and carries into y; last flags the final pixel.
module raster_counter
  import game_pkg::*;
(
  input  logic           clk,
  input  logic           resetn,
  input  logic           clr,
  input  logic           en,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           x_end, y_end;

  assign x_end = (x_q == X_W'(H_RES - 1));
  assign y_end = (y_q == Y_W'(V_RES - 1));

  // Clear wins over enable; the last pixel wraps both counters back to the origin.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (en) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = x_end & y_end;

endmodule

// File: rtl/frame_plotter.sv
// Raster-scan frame writer: queries the datapath for every pixel and emits one VGA plot per pixel.
module frame_plotter
  import game_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                game_mode,
  output logic [X_W-1:0]      q_x,
  output logic [Y_W-1:0]      q_y,
  input  logic                is_wall,
  input  logic                is_dude,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                done
);

  plot_state_e         state_q, state_d;
  logic                mode_q, mode_d;
  logic                cnt_clr, cnt_en, cnt_last;
  logic [COLOUR_W-1:0] colour_c;

  logic [X_W-1:0]      vga_x_q, vga_x_d;
  logic [Y_W-1:0]      vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0] vga_colour_q, vga_colour_d;
  logic                vga_plot_q, vga_plot_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  raster_counter u_raster (
    .clk    (clk),
    .resetn (resetn),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .x      (q_x),
    .y      (q_y),
    .last   (cnt_last)
  );

  // Player drawn over walls; menu mode ignores the datapath entirely.
  always_comb begin
    colour_c = BG_COLOUR;
    if (!mode_q)      colour_c = MENU_COLOUR;
    else if (is_dude) colour_c = DUDE_COLOUR;
    else if (is_wall) colour_c = WALL_COLOUR;
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          mode_d  = game_mode;
          cnt_clr = 1'b1;
        end
      end
      ST_SCAN: begin
        cnt_en       = 1'b1;
        vga_x_d      = q_x;
        vga_y_d      = q_y;
        vga_colour_d = colour_c;
        vga_plot_d   = 1'b1;
        if (cnt_last) state_d = ST_FLUSH;
      end
      // The last pixel's plot is on the outputs during this state.
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      mode_q       <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
